// File: rtl/alu_host_sequencer.sv
// Host-side sequencer for the ALU BEGIN/op_code/inbus/outbus/END protocol.
// Takes one request, launches the ALU, serializes operands, and returns two result words.
module alu_host_sequencer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic [7:0] req_a,
    input  logic [7:0] req_q,
    input  logic [7:0] req_m,
    output logic       alu_begin,
    output logic [1:0] alu_op_code,
    output logic [7:0] alu_inbus,
    input  logic [7:0] alu_outbus,
    input  logic       alu_end,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_hi,
    output logic [7:0] rsp_lo,
    output logic       rsp_timeout
);

    typedef enum logic [2:0] {
        IDLE, START, LOAD_A, LOAD_Q, LOAD_M, WAIT, RESP
    } state_t;

    localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

    state_t     r_state;
    logic [1:0] r_op;
    logic [7:0] r_a;
    logic [7:0] r_q;
    logic [7:0] r_m;
    logic [7:0] r_h0;
    logic [7:0] r_h1;
    logic [7:0] r_cnt;

    // Every output is assigned alongside the transition into the state that owns it,
    // so outputs are registered and line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_op        <= 2'b00;
            r_a         <= 8'h00;
            r_q         <= 8'h00;
            r_m         <= 8'h00;
            r_h0        <= 8'h00;
            r_h1        <= 8'h00;
            r_cnt       <= 8'h00;
            req_ready   <= 1'b1;
            alu_begin   <= 1'b0;
            alu_op_code <= 2'b00;
            alu_inbus   <= 8'h00;
            rsp_valid   <= 1'b0;
            rsp_hi      <= 8'h00;
            rsp_lo      <= 8'h00;
            rsp_timeout <= 1'b0;
        end else begin
            alu_begin <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        r_op        <= req_op;
                        r_a         <= req_a;
                        r_q         <= req_q;
                        r_m         <= req_m;
                        req_ready   <= 1'b0;
                        alu_begin   <= 1'b1;
                        alu_op_code <= req_op;
                        alu_inbus   <= 8'h00;
                        r_state     <= START;
                    end
                end
                START: begin
                    if (r_op == 2'b11) begin
                        alu_inbus <= r_a;
                        r_state   <= LOAD_A;
                    end else begin
                        alu_inbus <= r_q;
                        r_state   <= LOAD_Q;
                    end
                end
                LOAD_A: begin
                    alu_inbus <= r_q;
                    r_state   <= LOAD_Q;
                end
                LOAD_Q: begin
                    alu_inbus <= r_m;
                    r_state   <= LOAD_M;
                end
                LOAD_M: begin
                    alu_inbus <= 8'h00;
                    r_cnt     <= 8'h00;
                    r_state   <= WAIT;
                end
                WAIT: begin
                    r_h1 <= r_h0;
                    r_h0 <= alu_outbus;
                    // END wins over a timeout landing in the same cycle
                    if (alu_end) begin
                        rsp_valid   <= 1'b1;
                        rsp_hi      <= r_h1;
                        rsp_lo      <= r_h0;
                        rsp_timeout <= 1'b0;
                        r_state     <= RESP;
                    end else if (r_cnt == TO_LIM) begin
                        rsp_valid   <= 1'b1;
                        rsp_hi      <= 8'h00;
                        rsp_lo      <= 8'h00;
                        rsp_timeout <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid   <= 1'b0;
                        req_ready   <= 1'b1;
                        alu_op_code <= 2'b00;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    req_ready   <= 1'b1;
                    alu_op_code <= 2'b00;
                    alu_inbus   <= 8'h00;
                    rsp_valid   <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_host_sequencer.sv
// Randomized scoreboard bench for alu_host_sequencer with a mock ALU that
// computes results from the operand words it actually receives on inbus.
module tb_alu_host_sequencer;

    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [7:0] req_a, req_q, req_m;
    logic       alu_begin;
    logic [1:0] alu_op_code;
    logic [7:0] alu_inbus;
    logic [7:0] alu_outbus;
    logic       alu_end;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_hi, rsp_lo;
    logic       rsp_timeout;

    alu_host_sequencer #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_q(req_q), .req_m(req_m),
        .alu_begin(alu_begin), .alu_op_code(alu_op_code), .alu_inbus(alu_inbus),
        .alu_outbus(alu_outbus), .alu_end(alu_end),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_hi(rsp_hi), .rsp_lo(rsp_lo), .rsp_timeout(rsp_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [7:0] hi; logic [7:0] lo; logic to; } rsp_t;
    typedef struct { int dly; bit noend; bit spur; } mode_t;

    rsp_t       exp_q[$];
    logic [7:0] inb_q[$];
    mode_t      mode_q[$];
    int total = 0;
    int bad = 0;
    int bp_cnt = 0;
    int w_cyc = 0;
    int e_cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // What a real ALU returns: {A result, Q result}
    function automatic logic [15:0] alu_ref(input logic [1:0] op, input logic [7:0] a,
                                            input logic [7:0] q, input logic [7:0] m);
        logic [15:0] d;
        logic [15:0] qq;
        logic [15:0] rr;
        d = {a, q};
        case (op)
            2'd0: return {8'h00, 8'(q + m)};
            2'd1: return {8'h00, 8'(q - m)};
            2'd2: return 16'(q) * 16'(m);
            default: begin
                qq = d / {8'h00, m};
                rr = d % {8'h00, m};
                return {rr[7:0], qq[7:0]};
            end
        endcase
    endfunction

    // Mock ALU: captures operands, pushes A then Q results, then END
    initial begin : mock
        int phase;
        int need;
        int cnt;
        logic [1:0] op;
        logic [7:0] w[$];
        mode_t md;
        logic [15:0] r;
        phase = 0; need = 0; cnt = 0; op = 0; r = 0;
        md = '{dly: 0, noend: 0, spur: 0};
        alu_end = 1'b0;
        alu_outbus = 8'h00;
        forever begin
            @(negedge clk);
            alu_end = 1'b0;
            alu_outbus = 8'($urandom);
            if (reset) begin
                phase = 0;
                continue;
            end
            if (alu_begin) chk("begin_while_busy", phase, 0);
            if (phase == 0) begin
                if (alu_begin) begin
                    chk("inbus_at_begin", alu_inbus, 0);
                    chk("mode_avail", mode_q.size() > 0, 1);
                    if (mode_q.size() > 0) md = mode_q.pop_front();
                    op = alu_op_code;
                    need = (op == 2'd3) ? 3 : 2;
                    w.delete();
                    phase = 1;
                end
            end else if (phase == 1) begin
                w.push_back(alu_inbus);
                if (inb_q.size() > 0) chk("inbus_word", alu_inbus, inb_q.pop_front());
                else chk("inbus_extra", inb_q.size(), 1);
                if (md.spur && w.size() == need - 1) alu_end = 1'b1;
                if (w.size() == need) begin
                    r = alu_ref(op, (need == 3) ? w[0] : 8'h00, w[need-2], w[need-1]);
                    phase = 2;
                    cnt = 0;
                end
            end else begin
                if (cnt == 0) w_cyc = cyc;
                if (md.noend) begin
                    if (cnt == TO) phase = 0;
                end else if (cnt == md.dly) begin
                    alu_outbus = r[15:8];
                end else if (cnt == md.dly + 1) begin
                    alu_outbus = r[7:0];
                end else if (cnt == md.dly + 2) begin
                    alu_end = 1'b1;
                    e_cyc = cyc;
                    phase = 0;
                end
                cnt++;
            end
        end
    end

    // Response monitor: pops the scoreboard on each new response, drives rsp_ready
    initial begin : mon
        bit seen;
        rsp_t snap;
        rsp_t e;
        seen = 0;
        snap = '{hi: 0, lo: 0, to: 0};
        rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                seen = 0;
                rsp_ready = 1'b0;
                continue;
            end
            if (rsp_valid) begin
                if (!seen) begin
                    seen = 1;
                    snap = '{hi: rsp_hi, lo: rsp_lo, to: rsp_timeout};
                    if (exp_q.size() == 0) begin
                        chk("rsp_unexpected", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_hi", rsp_hi, e.hi);
                        chk("rsp_lo", rsp_lo, e.lo);
                        chk("rsp_timeout", rsp_timeout, e.to);
                        if (e.to) chk("timeout_latency", cyc - w_cyc, TO + 1);
                        else chk("rsp_latency", cyc - e_cyc, 1);
                    end
                end else begin
                    chk("rsp_stable", {rsp_hi, rsp_lo, rsp_timeout}, {snap.hi, snap.lo, snap.to});
                end
                chk("busy_ready_begin", {req_ready, alu_begin}, 0);
                if (bp_cnt > 0) begin
                    bp_cnt--;
                    rsp_ready = 1'b0;
                end else begin
                    rsp_ready = ($urandom_range(0, 3) != 0);
                end
                if (rsp_ready) seen = 0;
            end else begin
                rsp_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic finish_now();
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "bench stopped early");
    endtask

    // Called at a negedge; returns at the negedge of the alu_begin cycle
    task automatic do_req(input logic [1:0] op, input logic [7:0] a, input logic [7:0] q,
                          input logic [7:0] m, input mode_t md);
        logic [15:0] r;
        int n;
        r = alu_ref(op, a, q, m);
        if (md.noend) exp_q.push_back('{hi: 8'h00, lo: 8'h00, to: 1'b1});
        else exp_q.push_back('{hi: r[15:8], lo: r[7:0], to: 1'b0});
        mode_q.push_back(md);
        if (op == 2'd3) inb_q.push_back(a);
        inb_q.push_back(q);
        inb_q.push_back(m);
        req_valid = 1'b1;
        req_op = op; req_a = a; req_q = q; req_m = m;
        n = 0;
        while (!req_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            chk("req_accept_wait", n, 0);
            finish_now();
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_op = 2'($urandom); req_a = 8'($urandom); req_q = 8'($urandom); req_m = 8'($urandom);
        chk("begin_latency", alu_begin, 1);
        chk("begin_op", alu_op_code, op);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() > 0 || !req_ready) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk("drain_wait", n, 0);
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, "_ready"}, req_ready, 1);
        chk({nm, "_outs"}, {alu_begin, alu_op_code, alu_inbus, rsp_valid, rsp_hi, rsp_lo, rsp_timeout}, 0);
    endtask

    initial begin : stim
        mode_t md;
        logic [1:0] op;
        logic [7:0] m;
        reset = 1'b1;
        req_valid = 1'b0;
        req_op = 0; req_a = 0; req_q = 0; req_m = 0;
        repeat (2) @(negedge clk);
        chk_reset_outs("reset");
        reset = 1'b0;
        @(negedge clk);

        // add, then divide 300/10, END 5 cycles after M
        md = '{dly: 2, noend: 0, spur: 0};
        do_req(2'd0, 8'h00, 8'h12, 8'h34, md);
        do_req(2'd3, 8'h01, 8'h2C, 8'h0A, md);
        // ALU never ends
        md = '{dly: 0, noend: 1, spur: 0};
        do_req(2'd2, 8'h00, 8'h0F, 8'h11, md);
        drain();

        // response held 10 cycles while the next request waits
        bp_cnt = 10;
        md = '{dly: 1, noend: 0, spur: 0};
        do_req(2'd2, 8'h00, 8'hFF, 8'hFF, md);
        do_req(2'd1, 8'h00, 8'h05, 8'h09, md);
        drain();

        // reset while in LOAD_Q
        md = '{dly: 0, noend: 0, spur: 0};
        do_req(2'd0, 8'h00, 8'h77, 8'h22, md);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_outs("midreset");
        exp_q.delete();
        inb_q.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        do_req(2'd0, 8'h00, 8'h40, 8'h02, md);

        // END pulsed during LOAD_Q must be ignored
        md = '{dly: 3, noend: 0, spur: 1};
        do_req(2'd3, 8'h03, 8'hE8, 8'h07, md);
        md = '{dly: 0, noend: 0, spur: 1};
        do_req(2'd1, 8'h00, 8'h10, 8'h20, md);

        for (int i = 0; i < 30; i++) begin
            op = 2'($urandom);
            m = (op == 2'd3) ? 8'($urandom_range(1, 255)) : 8'($urandom);
            md = '{dly: $urandom_range(0, 4), noend: 0, spur: ($urandom_range(0, 3) == 0)};
            do_req(op, 8'($urandom), 8'($urandom), m, md);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
